// File: rtl/display_capture.sv
// rtl/display_capture.sv - rebuilds hex word, point and LE masks from a multiplexed 4-digit display bus
// Each digit is sampled once per stable AN dwell; a frame commits when all four digits are seen.
module display_capture #(
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  AN,
  input  logic [3:0]  HEX,
  input  logic        point,
  input  logic        LE,
  output logic [15:0] hexs,
  output logic [3:0]  points,
  output logic [3:0]  LEs,
  output logic        frame_valid,
  output logic [3:0]  seen,
  output logic        err,
  output logic        stale
);

  localparam int IW = $clog2(TIMEOUT + 1);
  localparam logic [7:0]    SETTLE_C  = 8'(SETTLE);
  localparam logic [7:0]    SAMPLE_AT = 8'(SETTLE - 1);
  localparam logic [IW-1:0] IDLE_MAX  = IW'(TIMEOUT);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);

  typedef enum logic {WAIT, HOLD} state_t;

  state_t        state;
  logic [3:0]    an_q;
  logic [7:0]    cnt;
  logic [IW-1:0] idle;
  logic [15:0]   sh_hex;
  logic [3:0]    sh_point;
  logic [3:0]    sh_le;
  logic          commit_pend;
  logic          err_pend;

  logic       legal;
  logic       blank;
  logic [1:0] idx;
  logic [3:0] bit_sel;
  logic [3:0] seen_next;
  logic       sample;
  logic       timeout_hit;

  always_comb begin
    legal   = 1'b1;
    blank   = 1'b0;
    idx     = 2'd0;
    bit_sel = 4'b0000;
    case (AN)
      4'b1110: begin idx = 2'd0; bit_sel = 4'b0001; end
      4'b1101: begin idx = 2'd1; bit_sel = 4'b0010; end
      4'b1011: begin idx = 2'd2; bit_sel = 4'b0100; end
      4'b0111: begin idx = 2'd3; bit_sel = 4'b1000; end
      4'b1111: begin legal = 1'b0; blank = 1'b1; end
      default: legal = 1'b0;
    endcase
  end

  assign seen_next   = seen | bit_sel;
  assign sample      = (state == WAIT) && (AN == an_q) && (cnt == SAMPLE_AT);
  assign timeout_hit = !sample && (idle == IDLE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= WAIT;
      an_q        <= 4'b1111;
      cnt         <= 8'd0;
      idle        <= '0;
      sh_hex      <= 16'h0000;
      sh_point    <= 4'b0000;
      sh_le       <= 4'b0000;
      commit_pend <= 1'b0;
      err_pend    <= 1'b0;
      hexs        <= 16'h0000;
      points      <= 4'b0000;
      LEs         <= 4'b0000;
      frame_valid <= 1'b0;
      seen        <= 4'b0000;
      err         <= 1'b0;
      stale       <= 1'b0;
    end else begin
      an_q <= AN;
      if (AN != an_q)
        cnt <= 8'd0;
      else if (cnt < SETTLE_C)
        cnt <= cnt + 8'd1;

      case (state)
        WAIT: if (sample) state <= HOLD;
        HOLD: if (AN != an_q) state <= WAIT;
        default: state <= WAIT;
      endcase

      // Commit and error are reported one edge after the deciding sample.
      frame_valid <= commit_pend;
      err         <= err_pend;
      err_pend    <= sample && !legal && !blank;

      if (sample)
        idle <= '0;
      else if (idle != IDLE_MAX)
        idle <= idle + IW'(1);

      if (commit_pend) begin
        hexs        <= sh_hex;
        points      <= sh_point;
        LEs         <= sh_le;
        seen        <= 4'b0000;
        stale       <= 1'b0;
        commit_pend <= 1'b0;
      end else if (sample && legal) begin
        sh_hex[{idx, 2'b00} +: 4] <= HEX;
        sh_point[idx]             <= point;
        sh_le[idx]                <= LE;
        seen                      <= seen_next;
        commit_pend               <= (seen_next == 4'b1111);
      end else if (timeout_hit) begin
        seen  <= 4'b0000;
        stale <= 1'b1;
      end
    end
  end

endmodule
